// File: rtl/tl_ul_host.sv
// tl_ul_host: single-outstanding TileLink-UL host adapter.
// Converts a simple core request (req/we/be/addr/wdata) into one A-channel
// beat, waits for the matching D-channel response, then gives the core a
// one-cycle completion pulse with read data and an error flag.
// Optional build macro TL_RESP_TIMEOUT_EN adds a response watchdog that
// abandons a transaction after TIMEOUT cycles and reports it as an error.
module tl_ul_host #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int READ_ONLY = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                reset,
    // core side
    input  logic                req_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                busy_o,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    // A channel
    output logic                a_valid_o,
    input  logic                a_ready_i,
    output logic [2:0]          a_opcode_o,
    output logic [ADDR_W-1:0]   a_address_o,
    output logic [DATA_W/8-1:0] a_mask_o,
    output logic [DATA_W-1:0]   a_data_o,
    // D channel
    input  logic                d_valid_i,
    output logic                d_ready_o,
    input  logic [2:0]          d_opcode_i,
    input  logic [DATA_W-1:0]   d_data_i,
    input  logic                d_error_i
);

    localparam int MASK_W = DATA_W / 8;

    // Clears the byte-offset bits so the A address is word aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(MASK_W - 1);

    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_SEND = 2'd1,
        ST_D_WAIT = 2'd2
    } state_e;

    state_e state_r;
    state_e next_state_s;

    logic              capture_s;
    logic              a_valid_s;
    logic              d_ready_s;
    logic              busy_s;
    logic              d_hs_s;
    logic              timeout_s;
    logic [2:0]        exp_d_opcode_s;

    logic [2:0]        a_opcode_r;
    logic [ADDR_W-1:0] a_address_r;
    logic [MASK_W-1:0] a_mask_r;
    logic [DATA_W-1:0] a_data_r;
    logic              rsp_valid_r;
    logic              err_r;
    logic [DATA_W-1:0] rdata_r;

    // A opcode for a core request; a read-only port always issues Get.
    function automatic logic [2:0] a_opcode_f(input logic we, input logic [MASK_W-1:0] be);
        if ((READ_ONLY != 0) || !we) begin
            return OP_GET;
        end else if (&be) begin
            return OP_PUT_FULL;
        end else begin
            return OP_PUT_PARTIAL;
        end
    endfunction

    // A mask for a core request; a Get with no enables fetches the whole word.
    function automatic logic [MASK_W-1:0] a_mask_f(input logic we, input logic [MASK_W-1:0] be);
        if (READ_ONLY != 0) begin
            return {MASK_W{1'b1}};
        end else if (!we && (be == {MASK_W{1'b0}})) begin
            return {MASK_W{1'b1}};
        end else begin
            return be;
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a handshake always wins over a watchdog expiry.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
                    next_state_s = ST_A_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_A_SEND: begin
                if (a_ready_i) begin
                    next_state_s = ST_D_WAIT;
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_A_SEND;
                end
            end
            ST_D_WAIT: begin
                if (d_valid_i) begin
                    next_state_s = ST_IDLE;
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_D_WAIT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State-decoded handshake and stall outputs.
    always_comb begin
        a_valid_s = 1'b0;
        d_ready_s = 1'b0;
        busy_s    = 1'b1;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s    = req_i;
                capture_s = req_i;
            end
            ST_A_SEND: begin
                a_valid_s = 1'b1;
            end
            ST_D_WAIT: begin
                d_ready_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
        d_hs_s = d_ready_s & d_valid_i;
    end

    // Captured A payload; held stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_opcode_r  <= 3'd0;
            a_address_r <= {ADDR_W{1'b0}};
            a_mask_r    <= {MASK_W{1'b0}};
            a_data_r    <= {DATA_W{1'b0}};
        end else if (capture_s) begin
            a_opcode_r  <= a_opcode_f(we_i, be_i);
            a_address_r <= addr_i & ALIGN_MASK;
            a_mask_r    <= a_mask_f(we_i, be_i);
            a_data_r    <= wdata_i;
        end else begin
            a_opcode_r  <= a_opcode_r;
            a_address_r <= a_address_r;
            a_mask_r    <= a_mask_r;
            a_data_r    <= a_data_r;
        end
    end

    // D opcode the slave must return for the transaction in flight.
    always_comb begin
        if (a_opcode_r == OP_GET) begin
            exp_d_opcode_s = OP_ACK_DATA;
        end else begin
            exp_d_opcode_s = OP_ACK;
        end
    end

    // Completion pulse, error flag and read-data holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
        end else if (d_hs_s) begin
            rsp_valid_r <= 1'b1;
            err_r       <= d_error_i | (d_opcode_i != exp_d_opcode_s);
            if (a_opcode_r == OP_GET) begin
                rdata_r <= d_data_i;
            end else begin
                rdata_r <= rdata_r;
            end
        end else if (timeout_s) begin
            rsp_valid_r <= 1'b1;
            err_r       <= 1'b1;
            rdata_r     <= rdata_r;
        end else begin
            rsp_valid_r <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= rdata_r;
        end
    end

`ifdef TL_RESP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] wdog_cnt_r;

    // Watchdog: restarts when a transaction leaves IDLE, counts while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if (capture_s) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_IDLE) begin
            wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
        end else begin
            wdog_cnt_r <= wdog_cnt_r;
        end
    end

    // Expiry: the count would reach TIMEOUT at the coming edge.
    assign timeout_s = (state_r != ST_IDLE) && (wdog_cnt_r == CNT_W'(TIMEOUT - 1));
`else
    // Without the watchdog a transaction waits for its response forever.
    assign timeout_s = 1'b0;
    if (TIMEOUT > 0) begin : g_no_wdog
    end
`endif

    assign busy_o      = busy_s;
    assign a_valid_o   = a_valid_s;
    assign d_ready_o   = d_ready_s;
    assign a_opcode_o  = a_opcode_r;
    assign a_address_o = a_address_r;
    assign a_mask_o    = a_mask_r;
    assign a_data_o    = a_data_r;
    assign rsp_valid_o = rsp_valid_r;
    assign err_o       = err_r;
    assign rdata_o     = rdata_r;

endmodule

// File: tb/tb_tl_ul_host.sv
// Directed testbench for tl_ul_host: a default instance plus a READ_ONLY
// instance sharing the same stimulus.
module tb_tl_ul_host;

    logic        clk;
    logic        reset;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic        a_ready_i;
    logic        d_valid_i;
    logic [2:0]  d_opcode_i;
    logic [31:0] d_data_i;
    logic        d_error_i;

    logic        busy_o;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        a_valid_o;
    logic [2:0]  a_opcode_o;
    logic [11:0] a_address_o;
    logic [3:0]  a_mask_o;
    logic [31:0] a_data_o;
    logic        d_ready_o;

    logic        ro_busy;
    logic        ro_rsp_valid;
    logic [31:0] ro_rdata;
    logic        ro_err;
    logic        ro_a_valid;
    logic [2:0]  ro_a_opcode;
    logic [11:0] ro_a_address;
    logic [3:0]  ro_a_mask;
    logic [31:0] ro_a_data;
    logic        ro_d_ready;

    int checks   = 0;
    int failures = 0;

    tl_ul_host #(.ADDR_W(12), .DATA_W(32), .READ_ONLY(0), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .err_o(err_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
        .a_address_o(a_address_o), .a_mask_o(a_mask_o), .a_data_o(a_data_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
        .d_data_i(d_data_i), .d_error_i(d_error_i)
    );

    tl_ul_host #(.ADDR_W(12), .DATA_W(32), .READ_ONLY(1), .TIMEOUT(8)) dut_ro (
        .clk(clk), .reset(reset),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(ro_busy), .rsp_valid_o(ro_rsp_valid), .rdata_o(ro_rdata), .err_o(ro_err),
        .a_valid_o(ro_a_valid), .a_ready_i(a_ready_i), .a_opcode_o(ro_a_opcode),
        .a_address_o(ro_a_address), .a_mask_o(ro_a_mask), .a_data_o(ro_a_data),
        .d_valid_i(d_valid_i), .d_ready_o(ro_d_ready), .d_opcode_i(d_opcode_i),
        .d_data_i(d_data_i), .d_error_i(d_error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full transaction with a_ready high; returns in the rsp_valid cycle.
    task automatic txn(input string tag, input logic we, input logic [3:0] be,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input logic [2:0] exp_op, input logic [3:0] exp_mask,
                       input logic [11:0] exp_addr, input logic [2:0] dop,
                       input logic [31:0] dd, input logic derr,
                       input logic exp_err, input logic [31:0] exp_rdata);
        req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
        a_ready_i = 1'b1;
        #1;
        chk({tag, "_busy_req"}, 32'(busy_o), 32'd1);
        tick();
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 12'h0; wdata_i = 32'h0;
        chk({tag, "_a_valid"}, 32'(a_valid_o), 32'd1);
        chk({tag, "_a_opcode"}, 32'(a_opcode_o), 32'(exp_op));
        chk({tag, "_a_address"}, 32'(a_address_o), 32'(exp_addr));
        chk({tag, "_a_mask"}, 32'(a_mask_o), 32'(exp_mask));
        chk({tag, "_a_data"}, a_data_o, wd);
        tick();
        chk({tag, "_a_valid_done"}, 32'(a_valid_o), 32'd0);
        chk({tag, "_d_ready"}, 32'(d_ready_o), 32'd1);
        d_valid_i = 1'b1; d_opcode_i = dop; d_data_i = dd; d_error_i = derr;
        tick();
        d_valid_i = 1'b0; d_opcode_i = 3'd0; d_data_i = 32'h0; d_error_i = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
        chk({tag, "_rdata"}, rdata_o, exp_rdata);
        chk({tag, "_d_ready_done"}, 32'(d_ready_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit observed=expired expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 12'h0;
        wdata_i = 32'h0; a_ready_i = 1'b0; d_valid_i = 1'b0; d_opcode_i = 3'd0;
        d_data_i = 32'h0; d_error_i = 1'b0;
        tick();
        tick();
        chk("rst_a_valid", 32'(a_valid_o), 32'd0);
        chk("rst_d_ready", 32'(d_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_a_address", 32'(a_address_o), 32'h0);
        chk("rst_a_mask", 32'(a_mask_o), 32'h0);

        // reset dominates a simultaneous request
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 12'h123;
        tick();
        chk("rst_dom_a_valid", 32'(a_valid_o), 32'd0);
        chk("rst_dom_addr", 32'(a_address_o), 32'h0);
        reset = 1'b0; req_i = 1'b0;
        tick();
        chk("rst_dom_idle", 32'(a_valid_o), 32'd0);

        // read with minimum latency
        txn("rd", 1'b0, 4'hF, 12'h10C, 32'h0, 3'd4, 4'hF, 12'h10C,
            3'd1, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF);
        tick();
        chk("rd_rsp_once", 32'(rsp_valid_o), 32'd0);
        chk("rd_rdata_hold", rdata_o, 32'hDEADBEEF);

        // full write, then a partial write issued in the completion cycle
        txn("wr_full", 1'b1, 4'hF, 12'h200, 32'h12345678, 3'd0, 4'hF, 12'h200,
            3'd0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
        txn("wr_part", 1'b1, 4'h3, 12'h203, 32'h0000A5A5, 3'd1, 4'h3, 12'h200,
            3'd0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
        chk("ro_opcode", 32'(ro_a_opcode), 32'd4);
        chk("ro_mask", 32'(ro_a_mask), 32'hF);
        tick();
        chk("wr_part_rsp_once", 32'(rsp_valid_o), 32'd0);

        // error paths
        txn("rd_derr", 1'b0, 4'h0, 12'h0FF, 32'h0, 3'd4, 4'hF, 12'h0FC,
            3'd1, 32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D);
        tick();
        txn("rd_badop", 1'b0, 4'hF, 12'h004, 32'h0, 3'd4, 4'hF, 12'h004,
            3'd0, 32'h11112222, 1'b0, 1'b1, 32'h11112222);
        tick();
        txn("wr_badop", 1'b1, 4'hF, 12'h008, 32'h0, 3'd0, 4'hF, 12'h008,
            3'd1, 32'h00000099, 1'b0, 1'b1, 32'h11112222);
        tick();
        chk("wr_badop_err_clear", 32'(err_o), 32'd0);

        // D response while idle is ignored
        d_valid_i = 1'b1; d_opcode_i = 3'd1; d_data_i = 32'h55AA55AA;
        tick();
        chk("idle_d_rsp", 32'(rsp_valid_o), 32'd0);
        chk("idle_d_rdata", rdata_o, 32'h11112222);
        chk("idle_d_ready", 32'(d_ready_o), 32'd0);
        tick();
        chk("idle_d_rsp2", 32'(rsp_valid_o), 32'd0);
        d_valid_i = 1'b0; d_opcode_i = 3'd0; d_data_i = 32'h0;

        // A-channel backpressure, with a stray D response during the stall
        a_ready_i = 1'b0;
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hC; addr_i = 12'h030; wdata_i = 32'hFEEDFACE;
        tick();
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 12'h0; wdata_i = 32'h0;
        d_valid_i = 1'b1; d_opcode_i = 3'd0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_a_valid", 32'(a_valid_o), 32'd1);
            chk("bp_a_data", a_data_o, 32'hFEEDFACE);
            chk("bp_a_address", 32'(a_address_o), 32'h030);
            chk("bp_a_mask", 32'(a_mask_o), 32'hC);
            chk("bp_a_opcode", 32'(a_opcode_o), 32'd1);
            chk("bp_busy", 32'(busy_o), 32'd1);
            chk("bp_no_rsp", 32'(rsp_valid_o), 32'd0);
            tick();
        end
        d_valid_i = 1'b0;
        a_ready_i = 1'b1;
        chk("bp_a_valid_end", 32'(a_valid_o), 32'd1);
        tick();
        chk("bp_d_ready", 32'(d_ready_o), 32'd1);
        chk("bp_busy_d", 32'(busy_o), 32'd1);
        d_valid_i = 1'b1; d_opcode_i = 3'd0;
        tick();
        d_valid_i = 1'b0;
        chk("bp_rsp", 32'(rsp_valid_o), 32'd1);
        chk("bp_err", 32'(err_o), 32'd0);
        tick();
        chk("bp_rsp_once", 32'(rsp_valid_o), 32'd0);
        chk("bp_busy_idle", 32'(busy_o), 32'd0);

        // reset while waiting for D; a late response must be dropped
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 12'h040;
        tick();
        req_i = 1'b0;
        tick();
        chk("rstd_d_ready_pre", 32'(d_ready_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_valid_i = 1'b1; d_opcode_i = 3'd1; d_data_i = 32'h77777777;
        chk("rstd_d_ready", 32'(d_ready_o), 32'd0);
        chk("rstd_a_valid", 32'(a_valid_o), 32'd0);
        chk("rstd_rsp", 32'(rsp_valid_o), 32'd0);
        tick();
        chk("rstd_rsp2", 32'(rsp_valid_o), 32'd0);
        chk("rstd_d_ready2", 32'(d_ready_o), 32'd0);
        chk("rstd_rdata", rdata_o, 32'h0);
        chk("rstd_busy", 32'(busy_o), 32'd0);
        d_valid_i = 1'b0; d_opcode_i = 3'd0; d_data_i = 32'h0;
        txn("rd_after_rst", 1'b0, 4'hF, 12'h044, 32'h0, 3'd4, 4'hF, 12'h044,
            3'd1, 32'h0BADCAFE, 1'b0, 1'b0, 32'h0BADCAFE);
        tick();

`ifdef TL_RESP_TIMEOUT_EN
        // watchdog expiry with no D response (TIMEOUT = 8)
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 12'h050; a_ready_i = 1'b1;
        tick();
        req_i = 1'b0;
        chk("to_rsp_c1", 32'(rsp_valid_o), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        tick();
        chk("to_rsp", 32'(rsp_valid_o), 32'd1);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_rdata", rdata_o, 32'h0BADCAFE);
        chk("to_d_ready", 32'(d_ready_o), 32'd0);
        txn("rd_after_to", 1'b0, 4'hF, 12'h058, 32'h0, 3'd4, 4'hF, 12'h058,
            3'd1, 32'h13572468, 1'b0, 1'b0, 32'h13572468);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
